pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline. Drives write-enables and bubble controls
//   for PC, F/D, D/X and X/M latches. Inputs: D-stage IR, X-stage IR, branch outcome, multdiv ready.
//   Sequences multi-cycle mult/div ops in X, with a watchdog.
//   Counts stall cycles for performance readout.
// PARAMETERS
//   MD_TIMEOUT  64  max cycles MD_WAIT holds before forced release
//   CNTW        32  width of stall/flush performance counters
// PORTS
//   clock          in   1     pipeline clock
//   reset_n        in   1     asynchronous, active-low reset
//   ir_fd          in   32    instruction in D stage (F/D latch output)
//   ir_dx          in   32    instruction in X stage (D/X latch output)
//   branch_taken   in   1     X-stage branch/jump resolved taken this cycle
//   md_ready       in   1     multdiv unit result valid (1-cycle pulse)
//   md_exception   in   1     multdiv overflow/div-by-zero, valid with md_ready
//   pc_we          out  1     PC write enable
//   fd_we          out  1     F/D latch write enable
//   fd_flush       out  1     load nop into F/D
//   dx_we          out  1     D/X latch write enable
//   dx_bubble      out  1     load nop into D/X
//   xm_bubble      out  1     load nop into X/M (ir=0, isRStatus=0)
//   md_start_mult  out  1     1-cycle start pulse to multdiv, multiply
//   md_start_div   out  1     1-cycle start pulse to multdiv, divide
//   md_sel         out  1     X/M o-input takes multdiv result; isRStatus_in = md_exception
//   md_timeout     out  1     sticky: watchdog fired since reset
//   stall_cnt      out  CNTW  cycles with pc_we=0 since reset
//   flush_cnt      out  CNTW  branch flush events since reset
// BEHAVIOUR
//   Decode (fixed ISA): opcode=ir[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2].
//   lw=01000; R-type=00000 with aluop 00110=mult, 00111=div; sw=00111; bne=00010; blt=00110;
//     jr=00100; bex=10110.
//   Reset (reset_n=0, async): state=RUN, counters=0, md_timeout=0. All outputs 0 while asserted.
//   FSM states: RUN, MD_WAIT.
//   RUN, priority high->low:
//     1. mult/div in ir_dx: assert md_start_* for exactly 1 cycle; go to MD_WAIT.
//        Same cycle: pc_we=fd_we=dx_we=0, xm_bubble=1.
//     2. branch_taken: all we=1, fd_flush=1, dx_bubble=1 (2 squashed); flush_cnt++.
//        Load-use ignored (D instr squashed).
//     3. load-use: ir_dx is lw, rd!=0, and (rd==rs of ir_fd, or rd==rt when ir_fd is R-type,
//        sw, bne or blt). Then pc_we=fd_we=0, dx_we=1, dx_bubble=1. Exactly 1 stall cycle.
//     4. otherwise all we=1, no bubbles.
//   MD_WAIT: pc_we=fd_we=dx_we=0, xm_bubble=1, watchdog counts up.
//     md_ready=1 -> md_sel=1, xm_bubble=0, dx_we=1, dx_bubble=1, pc_we=fd_we=1; next RUN.
//       The mult/div is not reissued (ir_dx becomes nop).
//     Watchdog reaches MD_TIMEOUT-1 without md_ready -> same release with md_sel=1,
//       isRStatus forced via md_sel path, md_timeout<=1.
//   md_ready in RUN: ignored. md_start never asserted in consecutive cycles.
//   Counters: stall_cnt++ on each cycle with pc_we=0 and reset_n=1. Both counters wrap at 2^CNTW.
//   Reset mid-MD_WAIT: FSM returns to RUN immediately; in-flight op abandoned (no md_sel).
// STRUCTURE
//   Shared package: opcode/aluop constants, field bit positions, state encoding.
//   One sub-module: hazard_detect (combinational load-use compare on ir_fd/ir_dx).
//   FSM, watchdog and counters live in the top.
// TESTING
//   lw r5 in X, add r3,r5,r2 in D -> 1 cycle pc_we=0, dx_bubble=1; stall_cnt 0->1.
//   lw r0 in X, add r3,r0,r2 in D -> no stall. Same pattern with branch_taken=1 -> flush only.
//   mult in X, md_ready at cycle 17 -> md_start_mult 1 cycle, stall cycles 0..16,
//     md_sel=1 at 17, RUN at 18.
//   div with md_ready+md_exception at cycle 33 -> md_sel=1, md_exception=1 passed,
//     pipeline resumes.
//   div, md_ready never -> release at MD_TIMEOUT-1, md_timeout=1 sticky until reset.
//   reset_n low during MD_WAIT -> all outputs 0 at once; RUN after release; counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - ISA decode constants, field helpers and FSM encoding for the hazard controller
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  function automatic logic [4:0] f_opcode(input logic [31:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] ir);
    return ir[ALU_MSB:ALU_LSB];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use hazard compare between D and X instructions
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_ir_fd,
  input  logic [31:0] i_ir_dx,
  output logic        o_load_use
);

  logic [4:0] w_dx_rd;
  logic [4:0] w_fd_op;
  logic       w_dx_is_lw;
  logic       w_fd_reads_rt;
  logic       w_unused;

  assign w_dx_rd    = f_rd(i_ir_dx);
  assign w_fd_op    = f_opcode(i_ir_fd);
  assign w_dx_is_lw = (f_opcode(i_ir_dx) == OP_LW);

  // Only these formats carry a real source register in the rt field; others hold immediate bits there.
  assign w_fd_reads_rt = (w_fd_op == OP_RTYPE) || (w_fd_op == OP_SW) ||
                         (w_fd_op == OP_BNE)   || (w_fd_op == OP_BLT);

  assign o_load_use = w_dx_is_lw && (w_dx_rd != 5'd0) &&
                      ((w_dx_rd == f_rs(i_ir_fd)) ||
                       (w_fd_reads_rt && (w_dx_rd == f_rt(i_ir_fd))));

  assign w_unused = ^{i_ir_dx[21:0], i_ir_fd[26:22], i_ir_fd[11:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer with mult/div wait FSM, watchdog and performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNTW       = 32
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic [31:0]     i_ir_fd,
  input  logic [31:0]     i_ir_dx,
  input  logic            i_branch_taken,
  input  logic            i_md_ready,
  input  logic            i_md_exception,
  output logic            o_pc_we,
  output logic            o_fd_we,
  output logic            o_fd_flush,
  output logic            o_dx_we,
  output logic            o_dx_bubble,
  output logic            o_xm_bubble,
  output logic            o_md_start_mult,
  output logic            o_md_start_div,
  output logic            o_md_sel,
  output logic            o_md_timeout,
  output logic [CNTW-1:0] o_stall_cnt,
  output logic [CNTW-1:0] o_flush_cnt
);

  localparam int             WDW     = $clog2(MD_TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(MD_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [WDW-1:0]  r_wd;
  logic            r_md_timeout;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_is_md;
  logic w_is_div;
  logic w_pc_we, w_fd_we, w_fd_flush, w_dx_we, w_dx_bubble, w_xm_bubble;
  logic w_start_mult, w_start_div, w_md_sel, w_force, w_flush_evt;
  logic w_unused;

  hazard_detect u_hazard_detect (
    .i_ir_fd    (i_ir_fd),
    .i_ir_dx    (i_ir_dx),
    .o_load_use (w_load_use)
  );

  assign w_is_div = (f_aluop(i_ir_dx) == ALU_DIV);
  assign w_is_md  = (f_opcode(i_ir_dx) == OP_RTYPE) &&
                    ((f_aluop(i_ir_dx) == ALU_MULT) || w_is_div);

  always_comb begin
    w_next       = r_state;
    w_pc_we      = 1'b1;
    w_fd_we      = 1'b1;
    w_dx_we      = 1'b1;
    w_fd_flush   = 1'b0;
    w_dx_bubble  = 1'b0;
    w_xm_bubble  = 1'b0;
    w_start_mult = 1'b0;
    w_start_div  = 1'b0;
    w_md_sel     = 1'b0;
    w_force      = 1'b0;
    w_flush_evt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_is_md) begin
          w_pc_we      = 1'b0;
          w_fd_we      = 1'b0;
          w_dx_we      = 1'b0;
          w_xm_bubble  = 1'b1;
          w_start_mult = !w_is_div;
          w_start_div  = w_is_div;
          w_next       = ST_MD_WAIT;
        end else if (i_branch_taken) begin
          w_fd_flush  = 1'b1;
          w_dx_bubble = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_load_use) begin
          w_pc_we     = 1'b0;
          w_fd_we     = 1'b0;
          w_dx_bubble = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        // Release retires the op into X/M and bubbles D/X so the mult/div is not reissued.
        if (i_md_ready || (r_wd == WD_LAST)) begin
          w_md_sel    = 1'b1;
          w_dx_bubble = 1'b1;
          w_force     = !i_md_ready;
          w_next      = ST_RUN;
        end else begin
          w_pc_we     = 1'b0;
          w_fd_we     = 1'b0;
          w_dx_we     = 1'b0;
          w_xm_bubble = 1'b1;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_RUN;
      r_wd         <= '0;
      r_md_timeout <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_md_timeout <= r_md_timeout | w_force;
      // Watchdog holds cycles elapsed since the start pulse.
      if (w_start_mult || w_start_div) begin
        r_wd <= WDW'(1);
      end else if (r_state == ST_MD_WAIT) begin
        r_wd <= r_wd + WDW'(1);
      end
      if (!w_pc_we) begin
        r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
      if (w_flush_evt) begin
        r_flush_cnt <= r_flush_cnt + CNTW'(1);
      end
    end
  end

  assign o_pc_we         = i_reset_n & w_pc_we;
  assign o_fd_we         = i_reset_n & w_fd_we;
  assign o_fd_flush      = i_reset_n & w_fd_flush;
  assign o_dx_we         = i_reset_n & w_dx_we;
  assign o_dx_bubble     = i_reset_n & w_dx_bubble;
  assign o_xm_bubble     = i_reset_n & w_xm_bubble;
  assign o_md_start_mult = i_reset_n & w_start_mult;
  assign o_md_start_div  = i_reset_n & w_start_div;
  assign o_md_sel        = i_reset_n & w_md_sel;
  assign o_md_timeout    = r_md_timeout;
  assign o_stall_cnt     = r_stall_cnt;
  assign o_flush_cnt     = r_flush_cnt;

  // The exception flag is routed to X/M outside this block; md_sel selects it there.
  assign w_unused = ^{i_md_exception, i_ir_dx[26:7], i_ir_dx[1:0]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a behavioural pipeline model
module tb_pipe_hazard_ctrl;

  localparam int MD_TIMEOUT = 64;
  localparam int CNTW       = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir_fd = '0;
  logic [31:0] ir_dx = '0;
  logic        branch = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exc = 1'b0;
  logic        pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_bubble;
  logic        start_mult, start_div, md_sel, md_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNTW(CNTW)) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_ir_fd         (ir_fd),
    .i_ir_dx         (ir_dx),
    .i_branch_taken  (branch),
    .i_md_ready      (md_ready),
    .i_md_exception  (md_exc),
    .o_pc_we         (pc_we),
    .o_fd_we         (fd_we),
    .o_fd_flush      (fd_flush),
    .o_dx_we         (dx_we),
    .o_dx_bubble     (dx_bubble),
    .o_xm_bubble     (xm_bubble),
    .o_md_start_mult (start_mult),
    .o_md_start_div  (start_div),
    .o_md_sel        (md_sel),
    .o_md_timeout    (md_timeout),
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: are we waiting on multdiv, cycles since its start pulse, sticky timeout, counters.
  bit          m_wait;
  int          m_wc;
  bit          m_to;
  logic [31:0] m_stall, m_flush;
  bit e_pc, e_fd, e_dx, e_ff, e_db, e_xb, e_sm, e_sd, e_sel, e_fevt;
  bit s_pc, s_fd, s_ff, s_dx, s_db, s_xb, s_sm, s_sd, s_sel;

  function automatic logic [31:0] r_ins(input logic [4:0] alu, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'b00000) && ((ir[6:2] == 5'b00110) || (ir[6:2] == 5'b00111));
  endfunction

  function automatic bit is_div(input logic [31:0] ir);
    return ir[6:2] == 5'b00111;
  endfunction

  function automatic bit load_use(input logic [31:0] fd, input logic [31:0] dx);
    logic [4:0] op;
    bit rt_src;
    op = fd[31:27];
    rt_src = (op == 5'b00000) || (op == 5'b00111) || (op == 5'b00010) || (op == 5'b00110);
    if (dx[31:27] != 5'b01000 || dx[26:22] == 5'd0) return 1'b0;
    return (dx[26:22] == fd[21:17]) || (rt_src && dx[26:22] == fd[16:12]);
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rd, rs, rt;
    logic [31:0] r;
    k  = $urandom_range(0, 8);
    rd = 5'($urandom_range(0, 7));
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    r  = $urandom;
    case (k)
      0, 1: return i_ins(5'b01000, rd, rs, r[16:0]);
      2:    return r_ins(5'($urandom_range(0, 5)), rd, rs, rt);
      3:    return {5'b00111, rd, rs, rt, r[11:0]};
      4:    return {5'b00010, rd, rs, rt, r[11:0]};
      5:    return {5'b00110, rd, rs, rt, r[11:0]};
      6:    return {5'b00100, rd, rs, rt, r[11:0]};
      7:    return {5'b10110, r[26:0]};
      default: return {5'b00101, rd, rs, rt, r[11:0]};
    endcase
  endfunction

  task automatic model_reset();
    m_wait = 0; m_wc = 0; m_to = 0; m_stall = '0; m_flush = '0;
  endtask

  task automatic model_eval();
    {e_pc, e_fd, e_dx, e_ff, e_db, e_xb, e_sm, e_sd, e_sel, e_fevt} = '0;
    if (!rst_n) return;
    if (!m_wait) begin
      if (is_md(ir_dx)) begin
        e_xb = 1; e_sm = !is_div(ir_dx); e_sd = is_div(ir_dx);
      end else if (branch) begin
        {e_pc, e_fd, e_dx} = 3'b111; e_ff = 1; e_db = 1; e_fevt = 1;
      end else if (load_use(ir_fd, ir_dx)) begin
        e_dx = 1; e_db = 1;
      end else begin
        {e_pc, e_fd, e_dx} = 3'b111;
      end
    end else if (md_ready || m_wc == MD_TIMEOUT - 1) begin
      {e_pc, e_fd, e_dx} = 3'b111; e_db = 1; e_sel = 1;
    end else begin
      e_xb = 1;
    end
  endtask

  task automatic model_clock();
    if (!rst_n) return;
    if (!e_pc) m_stall = m_stall + 1;
    if (e_fevt) m_flush = m_flush + 1;
    if (!m_wait) begin
      if (is_md(ir_dx)) begin m_wait = 1; m_wc = 1; end
    end else if (md_ready || m_wc == MD_TIMEOUT - 1) begin
      m_wait = 0;
      if (!md_ready) m_to = 1;
    end else begin
      m_wc++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One pipeline cycle: compare at negedge, advance the model at posedge, hand back at posedge+1.
  task automatic step();
    @(negedge clk);
    model_eval();
    {s_pc, s_fd, s_ff, s_dx, s_db, s_xb, s_sm, s_sd, s_sel} =
      {pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_bubble, start_mult, start_div, md_sel};
    chk("ctl{pc,fd,ff,dx,db,xb,sm,sd,sel}",
        32'({s_pc, s_fd, s_ff, s_dx, s_db, s_xb, s_sm, s_sd, s_sel}),
        32'({e_pc, e_fd, e_ff, e_dx, e_db, e_xb, e_sm, e_sd, e_sel}));
    chk("md_timeout", 32'(md_timeout), 32'(m_to));
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic run_md(input logic [31:0] ins, input int ready_at, input bit exc,
                        output int starts, output int stalls, output int sel_c);
    starts = 0; stalls = 0; sel_c = -1;
    ir_dx = ins;
    for (int c = 0; c < 4 * MD_TIMEOUT; c++) begin
      md_ready = (c == ready_at);
      md_exc   = (c == ready_at) && exc;
      step();
      if (s_sm || s_sd) starts++;
      if (!s_pc) stalls++;
      if (s_sel) begin sel_c = c; break; end
    end
    md_ready = 0; md_exc = 0; ir_dx = '0;
  endtask

  int starts, stalls, sel_c;

  initial begin
    model_reset();
    step();
    chk("reset pc_we", 32'(s_pc), 32'd0);
    chk("reset xm_bubble", 32'(s_xb), 32'd0);
    rst_n = 1;

    ir_dx = i_ins(5'b01000, 5'd5, 5'd1, 17'd4);
    ir_fd = r_ins(5'd0, 5'd3, 5'd5, 5'd2);
    step();
    chk("lu pc_we", 32'(s_pc), 32'd0);
    chk("lu dx_bubble", 32'(s_db), 32'd1);
    chk("lu stall_cnt", stall_cnt, 32'd1);
    ir_dx = '0;
    step();
    chk("post-lu pc_we", 32'(s_pc), 32'd1);

    ir_dx = i_ins(5'b01000, 5'd0, 5'd1, 17'd4);
    ir_fd = r_ins(5'd0, 5'd3, 5'd0, 5'd2);
    step();
    chk("lw r0 pc_we", 32'(s_pc), 32'd1);
    ir_dx = i_ins(5'b01000, 5'd5, 5'd1, 17'd4);
    ir_fd = r_ins(5'd0, 5'd3, 5'd5, 5'd2);
    branch = 1;
    step();
    chk("br fd_flush", 32'(s_ff), 32'd1);
    chk("br pc_we", 32'(s_pc), 32'd1);
    chk("br flush_cnt", flush_cnt, 32'd1);
    branch = 0; ir_dx = '0;

    run_md(r_ins(5'b00110, 5'd4, 5'd1, 5'd2), 17, 0, starts, stalls, sel_c);
    chk("mult starts", 32'(starts), 32'd1);
    chk("mult stalls", 32'(stalls), 32'd17);
    chk("mult sel cycle", 32'(sel_c), 32'd17);
    step();
    chk("mult resume pc_we", 32'(s_pc), 32'd1);

    run_md(r_ins(5'b00111, 5'd4, 5'd1, 5'd2), 33, 1, starts, stalls, sel_c);
    chk("div sel cycle", 32'(sel_c), 32'd33);
    chk("div stalls", 32'(stalls), 32'd33);
    chk("div timeout clear", 32'(md_timeout), 32'd0);

    run_md(r_ins(5'b00111, 5'd4, 5'd1, 5'd2), -1, 0, starts, stalls, sel_c);
    chk("wd sel cycle", 32'(sel_c), 32'(MD_TIMEOUT - 1));
    chk("wd stalls", 32'(stalls), 32'(MD_TIMEOUT - 1));
    chk("wd md_timeout", 32'(md_timeout), 32'd1);
    repeat (3) step();
    chk("wd sticky", 32'(md_timeout), 32'd1);

    ir_dx = r_ins(5'b00111, 5'd4, 5'd1, 5'd2);
    repeat (5) step();
    rst_n = 0;
    model_reset();
    #1;
    chk("async rst xm_bubble", 32'(xm_bubble), 32'd0);
    chk("async rst pc_we", 32'(pc_we), 32'd0);
    chk("async rst stall_cnt", stall_cnt, 32'd0);
    chk("async rst md_timeout", 32'(md_timeout), 32'd0);
    ir_dx = '0;
    step();
    rst_n = 1;
    step();
    chk("post-rst pc_we", 32'(s_pc), 32'd1);
    chk("post-rst md_sel", 32'(s_sel), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      ir_fd    = rand_instr();
      ir_dx    = ($urandom_range(0, 15) == 0) ?
                 r_ins(5'($urandom_range(6, 7)), 5'd4, 5'd1, 5'd2) : rand_instr();
      branch   = ($urandom_range(0, 5) == 0);
      md_ready = m_wait ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) == 0);
      md_exc   = md_ready && $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        model_reset();
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
